// File: rtl/spi_xfer_arbiter_if.sv
// rtl/spi_xfer_arbiter_if.sv - requester/pin bundle of the three-slave SPI transfer arbiter
interface spi_xfer_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        req;
    logic [DATA_W-1:0] tx0_i;
    logic [DATA_W-1:0] tx1_i;
    logic [DATA_W-1:0] tx2_i;
    logic              miso;
    logic [2:0]        gnt;
    logic [2:0]        done;
    logic [DATA_W-1:0] rx_data;
    logic              ss0;
    logic              ss1;
    logic              ss2;
    logic              sclk;
    logic              mosi;
    logic              busy;

    modport slave (
        input  req, tx0_i, tx1_i, tx2_i, miso,
        output gnt, done, rx_data, ss0, ss1, ss2, sclk, mosi, busy
    );

    modport master (
        output req, tx0_i, tx1_i, tx2_i, miso,
        input  gnt, done, rx_data, ss0, ss1, ss2, sclk, mosi, busy
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - arbitrates three byte requesters onto one mode-0 SPI link
// SPI_ARB_FIXED_PRIO_EN selects fixed priority req[0] > req[1] > req[2] instead of round-robin.
module spi_xfer_arbiter #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1
) (
    input logic               clk,
    input logic               rst_n,
    spi_xfer_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(2 * CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] tx_sr, tx_sr_nxt;
    logic [DATA_W-1:0] rx_sr, rx_sr_nxt;
    logic [DATA_W-1:0] rx_q, rx_q_nxt;
    logic [1:0]        sel, sel_nxt;
    logic [2:0]        gnt_q, gnt_nxt;
    logic [2:0]        done_q, done_nxt;
    logic [2:0]        ss_q, ss_nxt;
    logic              sclk_q, sclk_nxt;
    logic              mosi_q, mosi_nxt;
    logic              busy_q, busy_nxt;
    logic [1:0]        win;
    logic [DATA_W-1:0] win_tx;
    logic              grant;

    assign grant = (state == IDLE) && (|bus.req);

`ifdef SPI_ARB_FIXED_PRIO_EN
    always_comb begin
        if (bus.req[0])      win = 2'd0;
        else if (bus.req[1]) win = 2'd1;
        else                 win = 2'd2;
    end
`else
    logic [1:0] last, last_nxt;

    // search starts just after the previous winner
    always_comb begin
        case (last)
            2'd0:    win = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
            2'd1:    win = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
            default: win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
        endcase
        last_nxt = grant ? win : last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) last <= 2'd2;
        else        last <= last_nxt;
    end
`endif

    always_comb begin
        case (win)
            2'd0:    win_tx = bus.tx0_i;
            2'd1:    win_tx = bus.tx1_i;
            default: win_tx = bus.tx2_i;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        rx_q_nxt    = rx_q;
        sel_nxt     = sel;
        gnt_nxt     = 3'b000;
        done_nxt    = 3'b000;
        ss_nxt      = ss_q;
        sclk_nxt    = sclk_q;
        mosi_nxt    = mosi_q;
        busy_nxt    = busy_q;
        case (state)
            IDLE: begin
                if (grant) begin
                    sel_nxt     = win;
                    tx_sr_nxt   = win_tx;
                    mosi_nxt    = win_tx[DATA_W-1];
                    gnt_nxt     = 3'b001 << win;
                    ss_nxt      = ~(3'b001 << win);
                    busy_nxt    = 1'b1;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                if (cnt == HALF_END) begin
                    cnt_nxt     = '0;
                    sclk_nxt    = 1'b1;
                    rx_sr_nxt   = {rx_sr[DATA_W-2:0], bus.miso};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    state_nxt   = SHIFT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == HALF_END) begin
                    cnt_nxt = '0;
                    if (sclk_q) begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = HOLD;
                        end else begin
                            tx_sr_nxt = tx_sr << 1;
                            mosi_nxt  = tx_sr[DATA_W-2];
                        end
                    end else begin
                        sclk_nxt    = 1'b1;
                        rx_sr_nxt   = {rx_sr[DATA_W-2:0], bus.miso};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                // covers the trailing SCLK-low half-period plus the select hold time
                if (cnt == HOLD_END) begin
                    cnt_nxt   = '0;
                    ss_nxt    = 3'b111;
                    done_nxt  = 3'b001 << sel;
                    rx_q_nxt  = rx_sr;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_q    <= '0;
            sel     <= 2'd0;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            ss_q    <= 3'b111;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            rx_q    <= rx_q_nxt;
            sel     <= sel_nxt;
            gnt_q   <= gnt_nxt;
            done_q  <= done_nxt;
            ss_q    <= ss_nxt;
            sclk_q  <= sclk_nxt;
            mosi_q  <= mosi_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
    assign bus.ss0     = ss_q[0];
    assign bus.ss1     = ss_q[1];
    assign bus.ss2     = ss_q[2];
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
endmodule
